// File: rtl/nes_joypad_if.sv
// CPU/PIO-facing bus of the NES joypad keycode adapter.
// The master side drives the keycode word and the $4016 access strobes;
// the slave side (the adapter) returns the serial bit and its status.
interface nes_joypad_if;
  logic [31:0] keycode;
  logic        wr_en;
  logic        wr_data;
  logic        rd_en;
  logic        rd_data;
  logic [7:0]  buttons;
  logic        strobe;
  logic [3:0]  bits_read;

  modport master (
    output keycode, wr_en, wr_data, rd_en,
    input  rd_data, buttons, strobe, bits_read
  );

  modport slave (
    input  keycode, wr_en, wr_data, rd_en,
    output rd_data, buttons, strobe, bits_read
  );
endinterface

// File: rtl/nes_joypad_keycode.sv
// Presents four HID usage bytes as a standard NES controller at $4016:
// strobe latch, 8-bit serial shift-out (A first), then 1s once exhausted.
module nes_joypad_keycode #(
  parameter logic [7:0] KEY_A      = 8'h0E,
  parameter logic [7:0] KEY_B      = 8'h0D,
  parameter logic [7:0] KEY_SELECT = 8'h2C,
  parameter logic [7:0] KEY_START  = 8'h28,
  parameter logic [7:0] KEY_UP     = 8'h1A,
  parameter logic [7:0] KEY_DOWN   = 8'h16,
  parameter logic [7:0] KEY_LEFT   = 8'h04,
  parameter logic [7:0] KEY_RIGHT  = 8'h07,
  parameter bit         BLOCK_OPP  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  nes_joypad_if.slave  bus
);
  localparam int NUM_KEYS  = 8;
  localparam int NUM_BYTES = 4;

  // Index order matches the shift-out order: bit0 = A ... bit7 = Right.
  localparam logic [NUM_KEYS-1:0][7:0] KEY_MAP = {
    KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP, KEY_START, KEY_SELECT, KEY_B, KEY_A
  };

  logic [NUM_KEYS-1:0] hit;
  logic [7:0]          buttons_d, buttons_q;
  logic [7:0]          shreg_d, shreg_q;
  logic                strobe_d, strobe_q;
  logic [3:0]          bits_read_d, bits_read_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic match;
    // A key is pressed when any non-empty report byte carries its usage code.
    always_comb begin
      match = 1'b0;
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (bus.keycode[b*8 +: 8] != 8'h00 && bus.keycode[b*8 +: 8] == KEY_MAP[g])
          match = 1'b1;
      end
    end
    assign hit[g] = match;
  end

  // Opposing directions cancel so games never see an impossible D-pad state.
  always_comb begin
    buttons_d = hit;
    if (BLOCK_OPP) begin
      if (hit[4] && hit[5]) buttons_d[5:4] = 2'b00;
      if (hit[6] && hit[7]) buttons_d[7:6] = 2'b00;
    end
  end

  // Strobe latch and shift register; a write that raises strobe suppresses the shift.
  always_comb begin
    strobe_d    = strobe_q;
    shreg_d     = shreg_q;
    bits_read_d = bits_read_q;
    if (bus.wr_en) strobe_d = bus.wr_data;
    if (strobe_q || strobe_d) begin
      shreg_d     = buttons_q;
      bits_read_d = 4'd0;
    end else if (bus.rd_en) begin
      shreg_d = {1'b1, shreg_q[7:1]};
      if (bits_read_q < 4'd8) bits_read_d = bits_read_q + 4'd1;
    end
  end

  // State registers; reset leaves an all-ones shift register so reads return 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buttons_q   <= 8'h00;
      strobe_q    <= 1'b0;
      shreg_q     <= 8'hFF;
      bits_read_q <= 4'd0;
    end else begin
      buttons_q   <= buttons_d;
      strobe_q    <= strobe_d;
      shreg_q     <= shreg_d;
      bits_read_q <= bits_read_d;
    end
  end

  // While strobe is high the CPU sees button A live; otherwise the snapshot LSB.
  assign bus.rd_data   = strobe_q ? buttons_q[0] : shreg_q[0];
  assign bus.buttons   = buttons_q;
  assign bus.strobe    = strobe_q;
  assign bus.bits_read = bits_read_q;
endmodule

// File: tb/tb_nes_joypad_keycode.sv
// Directed bench for nes_joypad_keycode: decode table with serial readout,
// plus hand sequences for reset, strobe-live, snapshot and write/read overlap.
module tb_nes_joypad_keycode;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  nes_joypad_if bus ();
  nes_joypad_if bus2 ();

  nes_joypad_keycode #(.BLOCK_OPP(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  nes_joypad_keycode #(.BLOCK_OPP(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  assign bus2.keycode = bus.keycode;
  assign bus2.wr_en   = 1'b0;
  assign bus2.wr_data = 1'b0;
  assign bus2.rd_en   = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] kc;
    logic [7:0]  exp_blk;
    logic [7:0]  exp_raw;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic latch();
    write(1'b1);
    write(1'b0);
  endtask

  // Bit is sampled while rd_en is high, before the shifting edge.
  task automatic read_bit(output logic b);
    bus.rd_en = 1'b1;
    #3;
    b = bus.rd_data;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic b;
    vecs[0] = '{32'h00000000, 8'h00, 8'h00};
    vecs[1] = '{32'h0000000E, 8'h01, 8'h01};
    vecs[2] = '{32'h07002C1A, 8'h94, 8'h94};
    vecs[3] = '{32'h0000161A, 8'h00, 8'h30};
    vecs[4] = '{32'h00000704, 8'h00, 8'hC0};
    vecs[5] = '{32'h0E0D2C28, 8'h0F, 8'h0F};
    vecs[6] = '{32'h1A160407, 8'h00, 8'hF0};
    vecs[7] = '{32'h000D0016, 8'h22, 8'h22};
    vecs[8] = '{32'h0E0E0E0E, 8'h01, 8'h01};

    bus.keycode = 32'h0;
    bus.wr_en = 1'b0;
    bus.wr_data = 1'b0;
    bus.rd_en = 1'b0;
    #12;
    check("reset rd_data", bus.rd_data, 1);
    check("reset buttons", bus.buttons, 0);
    check("reset strobe", bus.strobe, 0);
    check("reset bits_read", bus.bits_read, 0);
    reset = 1'b0;
    tick();

    // Decode table, then a full latched readout of each pattern.
    for (int v = 0; v < 9; v++) begin
      bus.keycode = vecs[v].kc;
      tick();
      check($sformatf("vec%0d buttons blk", v), bus.buttons, vecs[v].exp_blk);
      check($sformatf("vec%0d buttons raw", v), bus2.buttons, vecs[v].exp_raw);
      latch();
      for (int i = 0; i < 9; i++) begin
        read_bit(b);
        check($sformatf("vec%0d read%0d", v, i), b, (i < 8) ? vecs[v].exp_blk[i] : 1'b1);
      end
      check($sformatf("vec%0d bits_read", v), bus.bits_read, 8);
    end

    // A only: reads 1,0x7 then 1s after exhaustion, bits_read saturates.
    bus.keycode = 32'h0000000E;
    tick();
    latch();
    for (int i = 0; i < 10; i++) begin
      read_bit(b);
      check($sformatf("a_only read%0d", i), b, (i == 0 || i >= 8) ? 1 : 0);
    end
    check("a_only bits_read sat", bus.bits_read, 8);

    // Async reset after three reads of a 0x0F snapshot.
    bus.keycode = 32'h0E0D2C28;
    tick();
    latch();
    for (int i = 0; i < 3; i++) read_bit(b);
    check("pre-reset bits_read", bus.bits_read, 3);
    check("pre-reset rd_data", bus.rd_data, 1'b1);
    bus.keycode = 32'h00000000;
    tick();
    #2 reset = 1'b1;
    #1;
    check("midreset rd_data", bus.rd_data, 1);
    check("midreset buttons", bus.buttons, 0);
    check("midreset bits_read", bus.bits_read, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Strobe high: A is live, reads never shift.
    write(1'b1);
    bus.keycode = 32'h0000000E;
    #1;
    check("live rd_data before", bus.rd_data, 0);
    tick();
    tick();
    check("live rd_data after", bus.rd_data, 1);
    read_bit(b);
    check("strobe read A", b, 1);
    check("strobe bits_read", bus.bits_read, 0);
    read_bit(b);
    check("strobe read A again", b, 1);
    write(1'b0);
    read_bit(b);
    check("post-strobe read A", b, 1);
    read_bit(b);
    check("post-strobe read B", b, 0);

    // Snapshot survives keycode release while strobe is low.
    latch();
    bus.keycode = 32'h0;
    tick();
    tick();
    check("snapshot buttons", bus.buttons, 0);
    read_bit(b);
    check("snapshot read A", b, 1);
    read_bit(b);
    check("snapshot read B", b, 0);

    // Write and read in the same cycle.
    bus.keycode = 32'h0E0D2C28;
    tick();
    latch();
    bus.wr_en = 1'b1; bus.wr_data = 1'b0; bus.rd_en = 1'b1;
    #3;
    check("wr0+rd rd_data", bus.rd_data, 1);
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("wr0+rd bits_read", bus.bits_read, 1);
    check("wr0+rd strobe", bus.strobe, 0);
    bus.keycode = 32'h0000000D;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 1'b1; bus.rd_en = 1'b1;
    #3;
    check("wr1+rd rd_data", bus.rd_data, 1);
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("wr1+rd strobe", bus.strobe, 1);
    check("wr1+rd bits_read", bus.bits_read, 0);
    check("wr1+rd live A", bus.rd_data, 0);
    write(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
